// File: rtl/conbus_rr.sv
// Wishbone shared bus: NM masters, NS slaves, registered round-robin owner, top-bit decode,
// error termination of unmapped accesses. Define CONBUS_TIMEOUT_EN to add the stall timeout.
module conbus_rr #(
  parameter int unsigned                NM       = 4,
  parameter int unsigned                NS       = 6,
  parameter int unsigned                S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0]     S_ADDR   = {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
  parameter int unsigned                TIMEOUT  = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [NM*32-1:0] m_adr_i,
  input  logic [NM*32-1:0] m_dat_i,
  input  logic [NM*4-1:0]  m_sel_i,
  input  logic [NM*3-1:0]  m_cti_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [31:0]      m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [31:0]      s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  output logic [2:0]       s_cti_o,
  output logic             s_we_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS*32-1:0] s_dat_i,
  input  logic [NS-1:0]    s_ack_i
);

  localparam int unsigned OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_OWNED} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [NM-1:0] err_q, err_d;
  logic          blk_q, blk_d;
  logic [31:0]   err_adr_q, err_adr_d;

  // Unpacked views of the flat buses so the owner/slave muxes index by a narrow select.
  logic [31:0] m_adr_arr [NM];
  logic [31:0] m_dat_arr [NM];
  logic [3:0]  m_sel_arr [NM];
  logic [2:0]  m_cti_arr [NM];
  logic [31:0] s_dat_arr [NS];

  for (genvar g = 0; g < NM; g++) begin : g_m_split
    assign m_adr_arr[g] = m_adr_i[g*32 +: 32];
    assign m_dat_arr[g] = m_dat_i[g*32 +: 32];
    assign m_sel_arr[g] = m_sel_i[g*4 +: 4];
    assign m_cti_arr[g] = m_cti_i[g*3 +: 3];
  end

  for (genvar g = 0; g < NS; g++) begin : g_s_split
    assign s_dat_arr[g] = s_dat_i[g*32 +: 32];
  end

  logic        owned;
  logic [31:0] own_adr;
  logic        own_cyc;
  logic        own_stb;

  assign owned   = (state_q == ST_OWNED);
  assign own_adr = m_adr_arr[owner_q];
  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_stb_i[owner_q];

  // Slave side always carries the current (or last) owner's request.
  assign s_adr_o = own_adr;
  assign s_dat_o = m_dat_arr[owner_q];
  assign s_sel_o = m_sel_arr[owner_q];
  assign s_cti_o = m_cti_arr[owner_q];
  assign s_we_o  = m_we_i[owner_q];

  // Round-robin scan starting just above the last owner.
  logic [OW-1:0] rr_idx [NM];
  logic          gnt_found;
  logic [OW-1:0] gnt_idx;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    for (int i = 0; i < int'(NM); i++) begin
      rr_idx[i] = OW'((int'(ptr_q) + i + 1) % int'(NM));
      if (!gnt_found && m_cyc_i[rr_idx[i]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx[i];
      end
    end
  end

  // Address decode; scanning downward lets the lowest matching index win.
  logic          hit;
  logic [SW-1:0] sel;

  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = int'(NS) - 1; k >= 0; k--) begin
      if (own_adr[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        hit = 1'b1;
        sel = SW'(k);
      end
    end
  end

  logic sel_ok;
  logic slv_ack;
  logic unmap_fire;
  logic same_adr;
  logic to_fire;

  assign sel_ok     = owned && hit;
  assign slv_ack    = sel_ok && own_cyc && s_ack_i[sel];
  assign same_adr   = (own_adr == err_adr_q);
  // One err per unmapped request: blocked until stb drops, the address moves or ownership ends.
  assign unmap_fire = owned && own_cyc && own_stb && !hit && !(blk_q && same_adr);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          state_d = ST_OWNED;
          owner_d = gnt_idx;
          ptr_d   = gnt_idx;
        end
      end
      ST_OWNED: begin
        if (!own_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    blk_d     = unmap_fire || (blk_q && owned && own_cyc && own_stb && same_adr);
    err_adr_d = unmap_fire ? own_adr : err_adr_q;
    err_d     = '0;
    if (unmap_fire || to_fire) err_d[owner_q] = 1'b1;
  end

`ifdef CONBUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    to_fire = 1'b0;
    if (!owned || !own_cyc || slv_ack || unmap_fire) begin
      cnt_d = '0;
    end else if (own_stb) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        to_fire = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= OW'(NM - 1);
      err_q     <= '0;
      blk_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      blk_q     <= blk_d;
      err_adr_q <= err_adr_d;
    end
  end

  // Strobes, ack and read data route only through the decoded slave of a live owner.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = '0;
    m_dat_o = '0;
    if (sel_ok) begin
      s_cyc_o[sel]     = own_cyc;
      s_stb_o[sel]     = own_stb;
      m_ack_o[owner_q] = slv_ack;
      m_dat_o          = s_dat_arr[sel];
    end
  end

  assign m_err_o = err_q;

endmodule

// File: tb/tb_conbus_rr.sv
// Directed bench for conbus_rr: reset, decode/read, round-robin order, bursts, unmapped err,
// stall timeout (CONBUS_TIMEOUT_EN) and asynchronous mid-transfer reset.
module tb_conbus_rr;

  localparam int NM = 4;
  localparam int NS = 6;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [NM*32-1:0] m_adr_i = '0;
  logic [NM*32-1:0] m_dat_i = '0;
  logic [NM*4-1:0]  m_sel_i = '0;
  logic [NM*3-1:0]  m_cti_i = '0;
  logic [NM-1:0]    m_we_i = '0;
  logic [NM-1:0]    m_cyc_i = '0;
  logic [NM-1:0]    m_stb_i = '0;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic [2:0]       s_cti_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS*32-1:0] s_dat_i = '0;
  logic [NS-1:0]    s_ack_i = '0;

  int total = 0;
  int bad = 0;

  always #5 sys_clk = ~sys_clk;

  conbus_rr #(
    .NM       (NM),
    .NS       (NS),
    .S_ADDR_W (3),
    .S_ADDR   ({3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000}),
    .TIMEOUT  (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_cti_i   (m_cti_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cti_o   (s_cti_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
    m_cyc_i[m]         = cyc;
    m_stb_i[m]         = stb;
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = adr ^ 32'h5555_0000;
    m_sel_i[m*4 +: 4]   = 4'hf;
    m_cti_i[m*3 +: 3]   = cti;
    m_we_i[m]          = (m == 1);
  endtask

  task automatic idle_all();
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = '0;
  endtask

  task automatic do_reset();
    idle_all();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    drive_m(0, 1'b1, 1'b1, 32'h0000_0000, 3'b000);
    s_ack_i = '1;
    for (int k = 0; k < NS; k++) s_dat_i[k*32 +: 32] = 32'hA000_0000 + k;
    tick();
    total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL reset_s_cyc got %b exp %b", s_cyc_o, 6'b0); end
    total++; if (s_stb_o !== 6'b0) begin bad++; $display("FAIL reset_s_stb got %b exp %b", s_stb_o, 6'b0); end
    total++; if (m_ack_o !== 4'b0) begin bad++; $display("FAIL reset_m_ack got %b exp %b", m_ack_o, 4'b0); end
    total++; if (m_err_o !== 4'b0) begin bad++; $display("FAIL reset_m_err got %b exp %b", m_err_o, 4'b0); end
    total++; if (m_dat_o !== 32'h0) begin bad++; $display("FAIL reset_m_dat got %h exp %h", m_dat_o, 32'h0); end
    idle_all();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    drive_m(0, 1'b1, 1'b1, 32'h4000_0010, 3'b000);
    settle();
    total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL read_idle s_cyc got %b exp %b", s_cyc_o, 6'b0); end
    tick();
    total++; if (s_cyc_o !== 6'b000100) begin bad++; $display("FAIL read_grant s_cyc got %b exp %b", s_cyc_o, 6'b000100); end
    total++; if (s_stb_o !== 6'b000100) begin bad++; $display("FAIL read_grant s_stb got %b exp %b", s_stb_o, 6'b000100); end
    total++; if (s_adr_o !== 32'h4000_0010) begin bad++; $display("FAIL read_adr got %h exp %h", s_adr_o, 32'h4000_0010); end
    total++; if (s_dat_o !== 32'h1555_0010) begin bad++; $display("FAIL read_wdat got %h exp %h", s_dat_o, 32'h1555_0010); end
    total++; if ({s_sel_o, s_cti_o, s_we_o} !== {4'hf, 3'b000, 1'b0}) begin bad++; $display("FAIL read_ctl got %h/%b/%b exp f/000/0", s_sel_o, s_cti_o, s_we_o); end
    tick();
    total++; if (m_ack_o !== 4'b0) begin bad++; $display("FAIL read_wait m_ack got %b exp %b", m_ack_o, 4'b0); end
    s_dat_i[2*32 +: 32] = 32'hDEAD_BEEF;
    s_ack_i = 6'b000101;
    settle();
    total++; if (m_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got %h exp %h", m_dat_o, 32'hDEAD_BEEF); end
    total++; if (m_ack_o !== 4'b0001) begin bad++; $display("FAIL read_ack got %b exp %b", m_ack_o, 4'b0001); end
    tick();
    idle_all();
    settle();
    total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL read_drop s_cyc got %b exp %b", s_cyc_o, 6'b0); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int m = 0; m < NM; m++) drive_m(m, 1'b1, 1'b1, 32'(m << 4), 3'b000);
    tick();
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NM;
      total++; if (s_adr_o !== 32'(g << 4)) begin bad++; $display("FAIL rr_owner_%0d adr got %h exp %h", k, s_adr_o, 32'(g << 4)); end
      total++; if (s_cyc_o !== 6'b000001) begin bad++; $display("FAIL rr_cyc_%0d got %b exp %b", k, s_cyc_o, 6'b000001); end
      s_ack_i[0] = 1'b1;
      settle();
      total++; if (m_ack_o !== 4'(1 << g)) begin bad++; $display("FAIL rr_ack_%0d got %b exp %b", k, m_ack_o, 4'(1 << g)); end
      tick();
      drive_m(g, 1'b0, 1'b0, 32'(g << 4), 3'b000);
      s_ack_i = '0;
      tick();
      if (k < 4) drive_m(g, 1'b1, 1'b1, 32'(g << 4), 3'b000);
      else idle_all();
      settle();
      total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL rr_dead_%0d s_cyc got %b exp %b", k, s_cyc_o, 6'b0); end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_burst();
    drive_m(1, 1'b1, 1'b1, 32'h0000_0100, 3'b010);
    tick();
    drive_m(0, 1'b1, 1'b1, 32'h0000_0200, 3'b000);
    for (int b = 0; b < 5; b++) begin
      if (b == 2) begin
        m_stb_i[1] = 1'b0;
        s_ack_i = '0;
        settle();
        total++; if ({s_cyc_o, s_stb_o} !== {6'b000001, 6'b000000}) begin bad++; $display("FAIL burst_gap cyc/stb got %b/%b exp 000001/000000", s_cyc_o, s_stb_o); end
      end else begin
        drive_m(1, 1'b1, 1'b1, 32'h0000_0100 + 32'(4 * b), (b == 4) ? 3'b111 : 3'b010);
        s_ack_i[0] = 1'b1;
        settle();
        total++; if (m_ack_o !== 4'b0010) begin bad++; $display("FAIL burst_beat_%0d m_ack got %b exp %b", b, m_ack_o, 4'b0010); end
      end
      tick();
    end
    drive_m(1, 1'b0, 1'b0, 32'h0000_0110, 3'b000);
    s_ack_i = '0;
    tick();
    total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL burst_dead s_cyc got %b exp %b", s_cyc_o, 6'b0); end
    tick();
    total++; if (s_adr_o !== 32'h0000_0200) begin bad++; $display("FAIL burst_handover adr got %h exp %h", s_adr_o, 32'h0000_0200); end
    total++; if (s_cyc_o !== 6'b000001) begin bad++; $display("FAIL burst_handover s_cyc got %b exp %b", s_cyc_o, 6'b000001); end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_unmapped();
    drive_m(0, 1'b1, 1'b1, 32'h6000_0000, 3'b000);
    s_ack_i = '1;
    tick();
    total++; if ({s_cyc_o, m_err_o, m_ack_o} !== 14'b0) begin bad++; $display("FAIL unmap_first cyc/err/ack got %b/%b/%b exp all 0", s_cyc_o, m_err_o, m_ack_o); end
    tick();
    total++; if (m_err_o !== 4'b0001) begin bad++; $display("FAIL unmap_err got %b exp %b", m_err_o, 4'b0001); end
    total++; if (m_ack_o !== 4'b0) begin bad++; $display("FAIL unmap_ack got %b exp %b", m_ack_o, 4'b0); end
    tick();
    total++; if (m_err_o !== 4'b0) begin bad++; $display("FAIL unmap_once got %b exp %b", m_err_o, 4'b0); end
    m_stb_i[0] = 1'b0;
    tick();
    total++; if (m_err_o !== 4'b0) begin bad++; $display("FAIL unmap_stb_low got %b exp %b", m_err_o, 4'b0); end
    m_stb_i[0] = 1'b1;
    tick();
    total++; if (m_err_o !== 4'b0001) begin bad++; $display("FAIL unmap_rearm got %b exp %b", m_err_o, 4'b0001); end
    tick();
    total++; if (m_err_o !== 4'b0) begin bad++; $display("FAIL unmap_pulse got %b exp %b", m_err_o, 4'b0); end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    drive_m(0, 1'b1, 1'b1, 32'h8000_0000, 3'b000);
    s_ack_i = 6'b000001;
    tick();
    total++; if (s_stb_o !== 6'b001000) begin bad++; $display("FAIL tmo_stb got %b exp %b", s_stb_o, 6'b001000); end
`ifdef CONBUS_TIMEOUT_EN
    for (int j = 1; j <= 10; j++) begin
      tick();
      total++; if (m_err_o !== ((j == 8) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL tmo_err_c%0d got %b exp %b", j, m_err_o, (j == 8) ? 4'b0001 : 4'b0000); end
    end
`else
    begin
      int errs;
      errs = 0;
      for (int j = 1; j <= 1000; j++) begin
        tick();
        if (m_err_o !== 4'b0) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL tmo_none err_cycles got %0d exp 0", errs); end
    end
`endif
    total++; if (s_stb_o !== 6'b001000) begin bad++; $display("FAIL tmo_stb_held got %b exp %b", s_stb_o, 6'b001000); end
    idle_all();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    drive_m(2, 1'b1, 1'b1, 32'h2000_0000, 3'b000);
    tick();
    drive_m(0, 1'b1, 1'b1, 32'h2000_0040, 3'b000);
    drive_m(3, 1'b1, 1'b1, 32'h2000_0300, 3'b000);
    s_ack_i[1] = 1'b1;
    settle();
    total++; if ({s_cyc_o, m_ack_o} !== {6'b000010, 4'b0100}) begin bad++; $display("FAIL rstmid_pre cyc/ack got %b/%b exp 000010/0100", s_cyc_o, m_ack_o); end
    #2;
    sys_rst_n = 1'b0;
    #1;
    total++; if ({s_cyc_o, s_stb_o, m_ack_o} !== 16'b0) begin bad++; $display("FAIL rstmid_async cyc/stb/ack got %b/%b/%b exp all 0", s_cyc_o, s_stb_o, m_ack_o); end
    tick();
    tick();
    sys_rst_n = 1'b1;
    settle();
    total++; if (s_cyc_o !== 6'b0) begin bad++; $display("FAIL rstmid_idle s_cyc got %b exp %b", s_cyc_o, 6'b0); end
    tick();
    total++; if (s_adr_o !== 32'h2000_0040) begin bad++; $display("FAIL rstmid_first_owner adr got %h exp %h", s_adr_o, 32'h2000_0040); end
    total++; if (m_ack_o !== 4'b0001) begin bad++; $display("FAIL rstmid_first_ack got %b exp %b", m_ack_o, 4'b0001); end
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_burst();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
